// File: rtl/pio_mailbox_pkg.sv
// Shared register offsets and field positions for the PIO mailbox.
package pio_mailbox_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;
    localparam logic [3:0] REG_IRQ_EN = 4'h2;
    localparam logic [3:0] REG_ERR    = 4'h3;
    localparam logic [3:0] REG_SHARED = 4'h4;

    localparam int unsigned STATUS_RX_VALID   = 0;
    localparam int unsigned STATUS_TX_FULL    = 1;
    localparam int unsigned STATUS_RX_LVL_LSB = 8;
    localparam int unsigned STATUS_TX_LVL_LSB = 16;

    localparam int unsigned ERR_OVERFLOW  = 0;
    localparam int unsigned ERR_UNDERFLOW = 1;

    // Pack the STATUS word from its fields; unused bits read 0.
    function automatic logic [31:0] status_word(input logic rx_valid, input logic tx_full,
                                                input logic [7:0] rx_lvl,
                                                input logic [7:0] tx_lvl);
        logic [31:0] w;
        w = '0;
        w[STATUS_RX_VALID] = rx_valid;
        w[STATUS_TX_FULL]  = tx_full;
        w[STATUS_RX_LVL_LSB +: 8] = rx_lvl;
        w[STATUS_TX_LVL_LSB +: 8] = tx_lvl;
        return w;
    endfunction

endpackage

// File: rtl/pio_mailbox_fifo.sv
// Flop-array FIFO for one mailbox direction. A push on full is accepted only when a pop
// frees the head slot in the same cycle; a pop on empty is refused.
module pio_mailbox_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              push_ok,
    output logic              pop_ok,
    output logic [ADDR_W:0]   level,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    import pio_mailbox_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W + 1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = count;
    // Empty head reads as zero so an underflowing read returns 0.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array: written only on an accepted push, no reset needed (head is gated).
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pio_mailbox.sv
// Dual-port mailbox: two FIFOs (A->B, B->A), per-port status/IRQ/error registers and a
// legacy shared word where port A wins same-cycle write collisions.
module pio_mailbox #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        address_a,
    input  logic [DATA_W-1:0] writedata_a,
    input  logic              write_a,
    input  logic              read_a,
    output logic [DATA_W-1:0] readdata_a,
    output logic              irq_a,
    input  logic [3:0]        address_b,
    input  logic [DATA_W-1:0] writedata_b,
    input  logic              write_b,
    input  logic              read_b,
    output logic [DATA_W-1:0] readdata_b,
    output logic              irq_b
);
    import pio_mailbox_pkg::*;

    logic            push_a, pop_a, push_b, pop_b;
    logic            a2b_push_ok, a2b_pop_ok, a2b_full, a2b_empty;
    logic            b2a_push_ok, b2a_pop_ok, b2a_full, b2a_empty;
    logic [ADDR_W:0] a2b_level, b2a_level;
    logic [DATA_W-1:0] a2b_head, b2a_head;

    logic [1:0]        err_a, err_b, err_a_d, err_b_d;
    logic              irq_en_a, irq_en_b;
    logic [DATA_W-1:0] shared_word;

    assign push_a = write_a & (address_a == REG_DATA);
    assign pop_a  = read_a  & (address_a == REG_DATA);
    assign push_b = write_b & (address_b == REG_DATA);
    assign pop_b  = read_b  & (address_b == REG_DATA);

    pio_mailbox_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_a2b (
        .clk       (clk),
        .reset     (reset),
        .push      (push_a),
        .push_data (writedata_a),
        .pop       (pop_b),
        .push_ok   (a2b_push_ok),
        .pop_ok    (a2b_pop_ok),
        .level     (a2b_level),
        .head      (a2b_head),
        .full      (a2b_full),
        .empty     (a2b_empty)
    );

    pio_mailbox_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_b2a (
        .clk       (clk),
        .reset     (reset),
        .push      (push_b),
        .push_data (writedata_b),
        .pop       (pop_a),
        .push_ok   (b2a_push_ok),
        .pop_ok    (b2a_pop_ok),
        .level     (b2a_level),
        .head      (b2a_head),
        .full      (b2a_full),
        .empty     (b2a_empty)
    );

    // Sticky error next-state: W1C clears, a same-cycle new error overrides the clear.
    always_comb begin
        logic [1:0] clr_a, clr_b, set_a, set_b;
        clr_a = (write_a && address_a == REG_ERR) ? writedata_a[1:0] : 2'b00;
        clr_b = (write_b && address_b == REG_ERR) ? writedata_b[1:0] : 2'b00;
        set_a = '0;
        set_b = '0;
        set_a[ERR_OVERFLOW]  = push_a & ~a2b_push_ok;
        set_a[ERR_UNDERFLOW] = pop_a  & ~b2a_pop_ok;
        set_b[ERR_OVERFLOW]  = push_b & ~b2a_push_ok;
        set_b[ERR_UNDERFLOW] = pop_b  & ~a2b_pop_ok;
        err_a_d = (err_a & ~clr_a) | set_a;
        err_b_d = (err_b & ~clr_b) | set_b;
    end

    // Control/status registers; port A has priority on the shared word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_a       <= '0;
            err_b       <= '0;
            irq_en_a    <= 1'b0;
            irq_en_b    <= 1'b0;
            shared_word <= '0;
        end else begin
            err_a <= err_a_d;
            err_b <= err_b_d;
            if (write_a && address_a == REG_IRQ_EN) irq_en_a <= writedata_a[0];
            if (write_b && address_b == REG_IRQ_EN) irq_en_b <= writedata_b[0];
            if (write_a && address_a == REG_SHARED) begin
                shared_word <= writedata_a;
            end else if (write_b && address_b == REG_SHARED) begin
                shared_word <= writedata_b;
            end
        end
    end

    assign irq_a = irq_en_a & ~b2a_empty;
    assign irq_b = irq_en_b & ~a2b_empty;

    // Port A read mux (zero latency).
    always_comb begin
        readdata_a = '0;
        case (address_a)
            REG_DATA:   readdata_a = b2a_head;
            REG_STATUS: readdata_a = status_word(~b2a_empty, a2b_full,
                                                 8'(b2a_level), 8'(a2b_level));
            REG_IRQ_EN: readdata_a[0] = irq_en_a;
            REG_ERR:    readdata_a[1:0] = err_a;
            REG_SHARED: readdata_a = shared_word;
            default:    readdata_a = '0;
        endcase
    end

    // Port B read mux (zero latency).
    always_comb begin
        readdata_b = '0;
        case (address_b)
            REG_DATA:   readdata_b = a2b_head;
            REG_STATUS: readdata_b = status_word(~a2b_empty, b2a_full,
                                                 8'(a2b_level), 8'(b2a_level));
            REG_IRQ_EN: readdata_b[0] = irq_en_b;
            REG_ERR:    readdata_b[1:0] = err_b;
            REG_SHARED: readdata_b = shared_word;
            default:    readdata_b = '0;
        endcase
    end

endmodule

// File: tb/tb_pio_mailbox.sv
// Self-checking bench for pio_mailbox with per-direction scoreboard queues.
module tb_pio_mailbox;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address_a = '0, address_b = '0;
    logic [31:0] writedata_a = '0, writedata_b = '0;
    logic        write_a = 1'b0, read_a = 1'b0, write_b = 1'b0, read_b = 1'b0;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_a2b [$];
    logic [31:0] q_b2a [$];

    pio_mailbox dut (
        .clk         (clk),
        .reset       (reset),
        .address_a   (address_a),
        .writedata_a (writedata_a),
        .write_a     (write_a),
        .read_a      (read_a),
        .readdata_a  (readdata_a),
        .irq_a       (irq_a),
        .address_b   (address_b),
        .writedata_b (writedata_b),
        .write_b     (write_b),
        .read_b      (read_b),
        .readdata_b  (readdata_b),
        .irq_b       (irq_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write transfer; DATA writes feed the scoreboard if the model has room.
    task automatic bus_wr(input bit port_b, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        if (port_b) begin
            address_b = addr; writedata_b = data; write_b = 1'b1;
        end else begin
            address_a = addr; writedata_a = data; write_a = 1'b1;
        end
        @(posedge clk);
        #1;
        write_a = 1'b0;
        write_b = 1'b0;
        if (addr == 4'h0) begin
            if (port_b && q_b2a.size() < DEPTH) q_b2a.push_back(data);
            if (!port_b && q_a2b.size() < DEPTH) q_a2b.push_back(data);
        end
    endtask

    // One read transfer; readdata sampled mid-cycle before the committing edge.
    task automatic bus_rd(input bit port_b, input logic [3:0] addr, input bit strobe,
                          output logic [31:0] data);
        @(negedge clk);
        if (port_b) begin
            address_b = addr; read_b = strobe;
        end else begin
            address_a = addr; read_a = strobe;
        end
        #1;
        data = port_b ? readdata_b : readdata_a;
        @(posedge clk);
        #1;
        read_a = 1'b0;
        read_b = 1'b0;
    endtask

    task automatic reg_check(input bit port_b, input logic [3:0] addr, input logic [31:0] exp,
                             input string tag);
        logic [31:0] d;
        bus_rd(port_b, addr, 1'b0, d);
        check(tag, d, exp);
    endtask

    // Pop the receive FIFO of a port and compare against the scoreboard head (0 if empty).
    task automatic pop_check(input bit port_b, input string tag);
        logic [31:0] d, exp;
        bus_rd(port_b, 4'h0, 1'b1, d);
        exp = 32'h0;
        if (port_b && q_a2b.size() > 0) exp = q_a2b.pop_front();
        if (!port_b && q_b2a.size() > 0) exp = q_b2a.pop_front();
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d, exp;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        reg_check(1'b0, 4'h1, 32'h0, "rst_status_a");
        reg_check(1'b1, 4'h1, 32'h0, "rst_status_b");
        reg_check(1'b1, 4'h0, 32'h0, "rst_data_b");
        reg_check(1'b0, 4'h4, 32'h0, "rst_shared");
        check("rst_irq_a", {31'b0, irq_a}, 32'h0);
        check("rst_irq_b", {31'b0, irq_b}, 32'h0);

        // Single message A->B
        bus_wr(1'b0, 4'h0, 32'h1234_5678);
        reg_check(1'b1, 4'h1, 32'h0000_0101, "one_status_b");
        pop_check(1'b1, "one_pop_b");
        reg_check(1'b1, 4'h1, 32'h0, "one_status_b_after");

        // Single message B->A
        bus_wr(1'b1, 4'h0, 32'hCAFE_F00D);
        reg_check(1'b0, 4'h1, 32'h0000_0101, "ba_status_a");
        pop_check(1'b0, "ba_pop_a");

        // Overflow: 9 pushes into an 8-deep FIFO
        for (int i = 0; i <= DEPTH; i++) bus_wr(1'b0, 4'h0, 32'(i));
        reg_check(1'b0, 4'h3, 32'h1, "ovf_err_a");
        reg_check(1'b0, 4'h1, 32'h0008_0002, "ovf_status_a");
        reg_check(1'b1, 4'h1, 32'h0000_0801, "ovf_status_b");
        for (int i = 0; i < DEPTH; i++) pop_check(1'b1, $sformatf("drain_%0d", i));
        bus_wr(1'b0, 4'h3, 32'h1);
        reg_check(1'b0, 4'h3, 32'h0, "ovf_err_clr");

        // Underflow on B
        pop_check(1'b1, "unf_data_b");
        reg_check(1'b1, 4'h3, 32'h2, "unf_err_b");
        reg_check(1'b1, 4'h1, 32'h0, "unf_status_b");
        bus_wr(1'b1, 4'h3, 32'h3);
        reg_check(1'b1, 4'h3, 32'h0, "unf_err_clr");

        // Push on full with same-cycle pop from the other side
        for (int i = 0; i < DEPTH; i++) bus_wr(1'b0, 4'h0, 32'h100 + 32'(i));
        @(negedge clk);
        address_a = 4'h0; writedata_a = 32'hBEEF_0001; write_a = 1'b1;
        address_b = 4'h0; read_b = 1'b1;
        #1;
        exp = q_a2b.pop_front();
        check("fullpp_pop_b", readdata_b, exp);
        @(posedge clk);
        #1;
        write_a = 1'b0; read_b = 1'b0;
        q_a2b.push_back(32'hBEEF_0001);
        reg_check(1'b1, 4'h1, 32'h0000_0801, "fullpp_status_b");
        reg_check(1'b0, 4'h3, 32'h0, "fullpp_err_a");
        reg_check(1'b0, 4'h1, 32'h0008_0002, "fullpp_status_a");
        for (int i = 0; i < DEPTH; i++) pop_check(1'b1, $sformatf("fullpp_drain_%0d", i));

        // Interrupt on B
        bus_wr(1'b1, 4'h2, 32'h1);
        reg_check(1'b1, 4'h2, 32'h1, "irq_en_b");
        check("irq_b_idle", {31'b0, irq_b}, 32'h0);
        bus_wr(1'b0, 4'h0, 32'h0000_00A5);
        check("irq_b_set", {31'b0, irq_b}, 32'h1);
        check("irq_a_quiet", {31'b0, irq_a}, 32'h0);
        pop_check(1'b1, "irq_pop_b");
        check("irq_b_clr", {31'b0, irq_b}, 32'h0);

        // Shared word collision: A wins
        @(negedge clk);
        address_a = 4'h4; writedata_a = 32'hAAAA_AAAA; write_a = 1'b1;
        address_b = 4'h4; writedata_b = 32'h5555_5555; write_b = 1'b1;
        @(posedge clk);
        #1;
        write_a = 1'b0; write_b = 1'b0;
        reg_check(1'b0, 4'h4, 32'hAAAA_AAAA, "shared_a");
        reg_check(1'b1, 4'h4, 32'hAAAA_AAAA, "shared_b");
        reg_check(1'b0, 4'h7, 32'h0, "unmapped_a");

        // Reset mid-burst
        for (int i = 0; i < 3; i++) bus_wr(1'b0, 4'h0, 32'h200 + 32'(i));
        @(negedge clk);
        address_a = 4'h0; writedata_a = 32'h0000_0299; write_a = 1'b1;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        write_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q_a2b.delete();
        q_b2a.delete();
        check("mid_rst_irq_b", {31'b0, irq_b}, 32'h0);
        reg_check(1'b1, 4'h1, 32'h0, "mid_rst_status_b");
        reg_check(1'b0, 4'h1, 32'h0, "mid_rst_status_a");
        reg_check(1'b0, 4'h4, 32'h0, "mid_rst_shared");
        reg_check(1'b1, 4'h2, 32'h0, "mid_rst_irq_en_b");
        reg_check(1'b1, 4'h0, 32'h0, "mid_rst_data_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
